clock_div_prog: RTL and testbench



---
 rtl/clock_div_pkg.sv | 8 +
 rtl/clock_div_chan.sv | 79 +++++++
 rtl/clock_div_prog.sv | 32 +++
 tb/tb_clock_div_prog.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_div_pkg.sv
// Shared constants for the programmable clock divider.
// Imported by the channel and the multi-channel top.
package clock_div_pkg;

  localparam int CLKDIV_MIN_RATIO = 2;
  localparam int CLKDIV_W         = 8;

endpackage

// File: rtl/clock_div_chan.sv
// One divider channel: ratio and enable are sampled only at idle
// or at the period boundary, so the output never glitches.
module clock_div_chan
  import clock_div_pkg::*;
#(
  parameter int W = CLKDIV_W
) (
  input  logic         in_clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] div_val,
  output logic         out_clk,
  output logic         tick,
  output logic         running
);

  logic [W-1:0] cnt;
  logic [W-1:0] r_act;
  logic [W-1:0] cnt_nxt;
  logic [W-1:0] r_last;
  logic [W-1:0] r_half;
  logic         startable;
  logic         at_bnd;

  assign startable = en && (div_val >= W'(CLKDIV_MIN_RATIO));
  assign cnt_nxt   = cnt + W'(1);
  assign r_last    = r_act - W'(1);
  assign r_half    = r_act >> 1;
  assign at_bnd    = (cnt == r_last);

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      r_act   <= '0;
      running <= 1'b0;
      out_clk <= 1'b0;
      tick    <= 1'b0;
    end else begin
      unique case (1'b1)
        !running: begin
          cnt <= '0;
          if (startable) begin
            r_act   <= div_val;
            running <= 1'b1;
            out_clk <= 1'b1;
            tick    <= 1'b1;
          end else begin
            out_clk <= 1'b0;
            tick    <= 1'b0;
          end
        end
        running && !at_bnd: begin
          cnt     <= cnt_nxt;
          out_clk <= (cnt_nxt < r_half);
          tick    <= 1'b0;
        end
        running && at_bnd: begin
          cnt <= '0;
          if (startable) begin
            r_act   <= div_val;
            out_clk <= 1'b1;
            tick    <= 1'b1;
          end else begin
            running <= 1'b0;
            out_clk <= 1'b0;
            tick    <= 1'b0;
          end
        end
        default: begin
          cnt     <= '0;
          running <= 1'b0;
          out_clk <= 1'b0;
          tick    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/clock_div_prog.sv
// Multi-channel programmable clock divider: NUM_CH independent
// channels sharing only the source clock and reset.
module clock_div_prog
  import clock_div_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int W      = CLKDIV_W
) (
  input  logic                in_clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   en,
  input  logic [NUM_CH*W-1:0] div_val,
  output logic [NUM_CH-1:0]   out_clk,
  output logic [NUM_CH-1:0]   tick,
  output logic [NUM_CH-1:0]   running
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clock_div_chan #(
      .W(W)
    ) u_chan (
      .in_clk (in_clk),
      .rst_n  (rst_n),
      .en     (en[c]),
      .div_val(div_val[c*W +: W]),
      .out_clk(out_clk[c]),
      .tick   (tick[c]),
      .running(running[c])
    );
  end

endmodule

// File: tb/tb_clock_div_prog.sv
// Scoreboard bench: per-channel period plans predict every output
// cycle; an independent monitor pops and compares after each edge.
module tb_clock_div_prog;

  localparam int NCH = 2;
  localparam int W   = 8;
  localparam int VW  = 3 * NCH;

  logic                in_clk;
  logic                rst_n;
  logic [NCH-1:0]      en;
  logic [NCH*W-1:0]    div_val;
  logic [NCH-1:0]      out_clk;
  logic [NCH-1:0]      tick;
  logic [NCH-1:0]      running;

  int n_cmp = 0;
  int n_bad = 0;

  logic [VW-1:0]  expq[$];
  logic [2:0]     plan[NCH][$];
  logic [NCH-1:0] last_tick;

  clock_div_prog #(
    .NUM_CH(NCH),
    .W     (W)
  ) dut (
    .in_clk (in_clk),
    .rst_n  (rst_n),
    .en     (en),
    .div_val(div_val),
    .out_clk(out_clk),
    .tick   (tick),
    .running(running)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Predict the outputs after the coming edge, then advance one cycle.
  task automatic step();
    logic [NCH-1:0] eo, et, er;
    logic [2:0]     v;
    int             r;
    for (int c = 0; c < NCH; c++) begin
      v = 3'b000;
      if (!rst_n) begin
        plan[c].delete();
      end else begin
        if (plan[c].size() == 0) begin
          r = int'(div_val[c*W +: W]);
          if (en[c] && r >= 2) begin
            for (int i = 0; i < r; i++)
              plan[c].push_back({(i < r / 2), (i == 0), 1'b1});
          end else begin
            plan[c].push_back(3'b000);
          end
        end
        v = plan[c].pop_front();
      end
      eo[c] = v[2];
      et[c] = v[1];
      er[c] = v[0];
    end
    last_tick = et;
    expq.push_back({eo, et, er});
    @(posedge in_clk);
    #2;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_div(input int c, input int r);
    div_val[c*W +: W] = W'(r);
  endtask

  task automatic wait_tick0(input int budget);
    int k;
    k = 0;
    while (!last_tick[0] && k < budget) begin
      step();
      k++;
    end
    check("tick0_wait", int'(last_tick[0]), 1);
  endtask

  initial begin : monitor
    logic [VW-1:0] e;
    forever begin
      @(posedge in_clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("outputs{out,tick,run}", int'({out_clk, tick, running}),
              int'(e));
      end
    end
  end

  initial begin : stim
    int k;
    rst_n     = 1'b0;
    en        = '0;
    div_val   = '0;
    last_tick = '0;
    #1;
    check("reset_out", int'(out_clk), 0);
    check("reset_tick", int'(tick), 0);
    check("reset_run", int'(running), 0);
    steps(2);
    rst_n = 1'b1;
    steps(2);

    // even then odd ratio, held enable
    set_div(0, 4);
    en[0] = 1'b1;
    steps(12);
    set_div(0, 5);
    steps(16);

    // ratio change at cnt=1
    set_div(0, 4);
    steps(6);
    wait_tick0(10);
    step();
    set_div(0, 6);
    steps(20);

    // stop at cnt=0
    wait_tick0(10);
    en[0] = 1'b0;
    steps(10);

    // illegal ratios never start
    set_div(0, 1);
    en[0] = 1'b1;
    steps(6);
    set_div(0, 0);
    steps(4);

    // asynchronous reset while high
    set_div(0, 6);
    step();
    rst_n = 1'b0;
    #1;
    check("async_rst_out", int'(out_clk[0]), 0);
    check("async_rst_run", int'(running[0]), 0);
    check("async_rst_tick", int'(tick[0]), 0);
    steps(2);
    rst_n = 1'b1;
    steps(8);

    // channel independence
    en = '0;
    steps(8);
    set_div(0, 3);
    set_div(1, 8);
    en = 2'b11;
    steps(30);
    for (int i = 0; i < 6; i++) begin
      en[1] = ~en[1];
      steps(int'($urandom_range(1, 9)));
    end

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0)
        en = NCH'($urandom_range(0, (1 << NCH) - 1));
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 15) == 0)
          set_div(int'($urandom_range(0, NCH - 1)),
                  int'($urandom_range(0, 40)));
        else
          set_div(int'($urandom_range(0, NCH - 1)),
                  int'($urandom_range(0, 9)));
      end
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      step();
    end

    k = 0;
    while (expq.size() > 0 && k < 10) begin
      @(posedge in_clk);
      #2;
      k++;
    end
    check("drain", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
